food_spawner: RTL and testbench

//  Responder for the snake's box-eaten request: on each new create_new_box assertion, draws a

---
 rtl/food_spawner_pkg.sv | 21 ++
 rtl/food_spawner_lfsr16.sv | 24 ++
 rtl/food_spawner.sv | 141 ++++++++++++++
 tb/tb_food_spawner.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/food_spawner_pkg.sv
// Shared playfield geometry for the snake game: 10-pixel grid, 64x48 cells,
// box rows offset by one cell so the top row stays free for the score bar.
package food_spawner_pkg;

   localparam int GRID    = 10;
   localparam int X_MAX   = 630;
   localparam int Y_MIN   = 10;
   localparam int Y_MAX   = 480;
   localparam int X_W     = 10;
   localparam int Y_W     = 9;
   localparam int X_CELLS = 64;
   localparam int Y_CELLS = 48;

   // Cell index to pixel coordinate; shift-add keeps this a couple of adders.
   function automatic logic [X_W-1:0] times_grid(input logic [6:0] i);
      logic [X_W-1:0] w;
      w = {3'b000, i};
      return (w << 3) + (w << 1);
   endfunction

endpackage

// File: rtl/food_spawner_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), stepping every cycle.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] q
);

   logic [15:0] q_q;
   logic        fb_d;

   assign fb_d = q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10];
   assign q    = q_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= SEED;
      end else begin
         q_q <= {q_q[14:0], fb_d};
      end
   end

endmodule

// File: rtl/food_spawner.sv
// Places a new food box on a random grid cell each time the snake eats the
// current one, and flags pixels inside the box for the VGA colour mux.
module food_spawner
   import food_spawner_pkg::*;
#(
   parameter logic [15:0]    SEED      = 16'hACE1,
   parameter logic [X_W-1:0] INIT_X    = 10'd200,
   parameter logic [Y_W-1:0] INIT_Y    = 9'd200,
   parameter int unsigned    MAX_TRIES = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           create_new_box,
   input  logic [X_W-1:0] x_pos,
   input  logic [Y_W-1:0] y_pos,
   output logic [X_W-1:0] box_x,
   output logic [Y_W-1:0] box_y,
   output logic           box_valid,
   output logic           box_busy,
   output logic           box_vga
);

   typedef enum logic {IDLE, DRAW} state_t;

   localparam int          TW      = $clog2(MAX_TRIES + 2);
   localparam logic [TW-1:0] MAX_T = TW'(MAX_TRIES);
   localparam logic [5:0]  INIT_XI = 6'(int'(INIT_X) / GRID);

   if (SEED == 16'h0000) begin : g_seed_chk
      $error("food_spawner: SEED must be nonzero");
   end
   if ((int'(INIT_X) % GRID) != 0 || int'(INIT_X) > X_MAX) begin : g_init_x_chk
      $error("food_spawner: INIT_X must be a multiple of 10 in 0..630");
   end
   if ((int'(INIT_Y) % GRID) != 0 || int'(INIT_Y) < Y_MIN || int'(INIT_Y) > Y_MAX) begin : g_init_y_chk
      $error("food_spawner: INIT_Y must be a multiple of 10 in 10..480");
   end

   logic [15:0]    lfsr;
   logic           unused_lfsr_bits;
   state_t         state_q;
   logic           req_q;
   logic [TW-1:0]  tries_q;
   logic [X_W-1:0] box_x_q;
   logic [Y_W-1:0] box_y_q;
   logic [5:0]     box_xi_q;
   logic           box_valid_q;
   logic           box_busy_q;

   logic           rise_d;
   logic [5:0]     xi_d;
   logic [5:0]     yi_d;
   logic [X_W-1:0] cand_x_d;
   logic [X_W-1:0] cand_y10_d;
   logic [Y_W-1:0] cand_y_d;
   logic           reject_d;
   logic           accept_d;
   logic [5:0]     fall_xi_d;
   logic [X_W-1:0] fall_x_d;
   logic [X_W-1:0] box_x_end_d;
   logic [Y_W-1:0] box_y_end_d;

   lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .q     (lfsr)
   );

   assign unused_lfsr_bits = ^lfsr[15:12];

   assign rise_d     = create_new_box & ~req_q;
   assign xi_d       = lfsr[5:0];
   assign yi_d       = lfsr[11:6];
   assign cand_x_d   = times_grid({1'b0, xi_d});
   assign cand_y10_d = times_grid({1'b0, yi_d} + 7'd1);
   assign cand_y_d   = cand_y10_d[Y_W-1:0];
   // Rows 48..63 fall off the playfield; redrawing the current spot would look like no move.
   assign reject_d   = (yi_d >= 6'(Y_CELLS)) || (cand_x_d == box_x_q && cand_y_d == box_y_q);
   assign accept_d   = (MAX_TRIES != 0) && !reject_d;
   assign fall_xi_d  = box_xi_q + 6'd1;
   assign fall_x_d   = times_grid({1'b0, fall_xi_d});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         req_q       <= 1'b0;
         tries_q     <= '0;
         box_x_q     <= INIT_X;
         box_y_q     <= INIT_Y;
         box_xi_q    <= INIT_XI;
         box_valid_q <= 1'b0;
         box_busy_q  <= 1'b0;
      end else begin
         req_q       <= create_new_box;
         box_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rise_d) begin
                  state_q    <= DRAW;
                  box_busy_q <= 1'b1;
                  tries_q    <= '0;
               end
            end
            DRAW: begin
               if (accept_d) begin
                  box_x_q     <= cand_x_d;
                  box_y_q     <= cand_y_d;
                  box_xi_q    <= xi_d;
                  box_valid_q <= 1'b1;
                  box_busy_q  <= 1'b0;
                  state_q     <= IDLE;
               end else if (tries_q == MAX_T) begin
                  // Out of retries: step one column right, which always differs from the old spot.
                  box_x_q     <= fall_x_d;
                  box_xi_q    <= fall_xi_d;
                  box_valid_q <= 1'b1;
                  box_busy_q  <= 1'b0;
                  state_q     <= IDLE;
               end else begin
                  tries_q <= tries_q + TW'(1);
               end
            end
            default: begin
               state_q    <= IDLE;
               box_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign box_x     = box_x_q;
   assign box_y     = box_y_q;
   assign box_valid = box_valid_q;
   assign box_busy  = box_busy_q;

   assign box_x_end_d = box_x_q + 10'(GRID);
   assign box_y_end_d = box_y_q + 9'(GRID);
   assign box_vga = (x_pos > box_x_q) && (x_pos < box_x_end_d) &&
                    (y_pos > box_y_q) && (y_pos < box_y_end_d);

endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner: a reference LFSR/draw model predicts each new
// box into a scoreboard, popped and compared when box_valid pulses.
module tb_food_spawner;

   logic       clk;
   logic       rst_n;
   logic       create_new_box;
   logic       req_fb;
   logic [9:0] x_pos;
   logic [8:0] y_pos;
   logic [9:0] box_x, fb_x;
   logic [8:0] box_y, fb_y;
   logic       box_valid, box_busy, box_vga;
   logic       fb_valid, fb_busy, fb_vga;

   typedef struct {int x; int y; int lat;} exp_t;

   exp_t        sb[$];
   int          compared   = 0;
   int          mismatched = 0;
   logic [15:0] m_lfsr;
   int          mx[2];
   int          my[2];
   logic [63:0] hits;

   food_spawner dut (
      .clk(clk), .rst_n(rst_n), .create_new_box(create_new_box),
      .x_pos(x_pos), .y_pos(y_pos), .box_x(box_x), .box_y(box_y),
      .box_valid(box_valid), .box_busy(box_busy), .box_vga(box_vga)
   );

   food_spawner #(.INIT_X(10'd630), .INIT_Y(9'd120), .MAX_TRIES(0)) dut_fb (
      .clk(clk), .rst_n(rst_n), .create_new_box(req_fb),
      .x_pos(x_pos), .y_pos(y_pos), .box_x(fb_x), .box_y(fb_y),
      .box_valid(fb_valid), .box_busy(fb_busy), .box_vga(fb_vga)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 16'hACE1;
      else        m_lfsr <= step(m_lfsr);
   end

   // l0 is the LFSR value visible before the edge that samples the request.
   function automatic exp_t predict(input logic [15:0] l0, input int cx, input int cy, input int maxt);
      exp_t        e;
      logic [15:0] v;
      int          xi, yi, nx, ny;
      v = step(l0);
      for (int t = 0; t <= maxt; t++) begin
         xi = int'(v[5:0]);
         yi = int'(v[11:6]);
         nx = xi * 10;
         ny = (yi + 1) * 10;
         if (maxt != 0 && yi < 48 && !(nx == cx && ny == cy)) begin
            e.x = nx; e.y = ny; e.lat = t + 2;
            return e;
         end
         v = step(v);
      end
      e.x = ((cx / 10 + 1) % 64) * 10;
      e.y = cy;
      e.lat = maxt + 2;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic run_req(input bit fb, input int hold, input int idx);
      exp_t e, got;
      int   budget, pulses, busy_cnt;
      bit   found;
      logic v, b;
      budget = (hold > 0) ? hold : ((fb ? 0 : 8) + 4);
      @(negedge clk);
      e = predict(m_lfsr, mx[fb], my[fb], fb ? 0 : 8);
      sb.push_back(e);
      if (fb) req_fb = 1'b1; else create_new_box = 1'b1;
      found = 1'b0; pulses = 0; busy_cnt = 0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         v = fb ? fb_valid : box_valid;
         b = fb ? fb_busy : box_busy;
         if (b) busy_cnt++;
         if (v) begin
            pulses++;
            if (!found) begin
               found = 1'b1;
               got = sb.pop_front();
               chk("box_x", fb ? 32'(fb_x) : 32'(box_x), got.x);
               chk("box_y", fb ? 32'(fb_y) : 32'(box_y), got.y);
               chk("latency", c, got.lat);
               if (!fb && int'(box_x) < 640) hits[int'(box_x) / 10] = 1'b1;
               $display("req %0d dut%0d: box=(%0d,%0d) latency=%0d", idx, fb,
                        fb ? fb_x : box_x, fb ? fb_y : box_y, c);
            end
         end
         if (found && hold == 0) break;
      end
      chk("valid_seen", found, 1);
      if (!found) void'(sb.pop_front());
      if (hold > 0) begin
         chk("pulse_count", pulses, 1);
         chk("busy_cycles", busy_cnt, e.lat - 1);
      end
      mx[fb] = e.x;
      my[fb] = e.y;
      if (fb) req_fb = 1'b0; else create_new_box = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; create_new_box = 1'b0; req_fb = 1'b0;
      x_pos = 10'd205; y_pos = 9'd205;
      mx = '{200, 630}; my = '{200, 120}; hits = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_box_x", box_x, 200);
      chk("rst_box_y", box_y, 200);
      chk("rst_valid", box_valid, 0);
      chk("rst_busy", box_busy, 0);
      chk("rst_vga_center", box_vga, 1);
      chk("rst_fb_x", fb_x, 630);
      rst_n = 1'b1;

      // Pixel edges around box (200,200)
      x_pos = 10'd200; y_pos = 9'd205; #1 chk("vga_left_edge", box_vga, 0);
      x_pos = 10'd210;                 #1 chk("vga_right_edge", box_vga, 0);
      x_pos = 10'd201; y_pos = 9'd209; #1 chk("vga_inner_corner", box_vga, 1);
      x_pos = 10'd209; y_pos = 9'd201; #1 chk("vga_inner_corner2", box_vga, 1);
      x_pos = 10'd205; y_pos = 9'd200; #1 chk("vga_top_edge", box_vga, 0);
      y_pos = 9'd210;                  #1 chk("vga_bottom_edge", box_vga, 0);

      // Level held high: one draw only
      run_req(1'b0, 1000, 0);

      // Many spaced requests
      for (int i = 1; i <= 1000; i++) run_req(1'b0, 0, i);
      chk("x_cells_hit", $countones(hits), 64);

      // Fallback-only instance: wraps column 63 to 0, row unchanged
      run_req(1'b1, 0, 0);
      run_req(1'b1, 0, 1);

      // Reset in the middle of a draw
      @(negedge clk);
      create_new_box = 1'b1;
      @(negedge clk);
      chk("busy_before_reset", box_busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_box_x", box_x, 200);
      chk("midreset_box_y", box_y, 200);
      chk("midreset_busy", box_busy, 0);
      chk("midreset_valid", box_valid, 0);
      create_new_box = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("reset_no_valid", box_valid, 0);
      end
      rst_n = 1'b1;
      mx = '{200, 630}; my = '{200, 120};
      sb.delete();
      for (int i = 0; i < 5; i++) run_req(1'b0, 0, 2000 + i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
